// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store stage: request/ack data-memory access with lane steering and timeout
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        memwrite,
  input  logic [1:0]  memsize,
  input  logic        memsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        off_q, size_q;
  logic              signed_q;
  logic              misaligned, start, timeout_hit;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc, shifted, load_val;

  always_comb begin
    misaligned = (memsize == 2'b11)
               | ((memsize == 2'b01) & addr[0])
               | ((memsize == 2'b10) & (addr[1:0] != 2'b00));
    start       = (state == IDLE) & valid_i & ~misaligned;
    timeout_hit = (cnt + 1'b1) == TIMEOUT_CNT;
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (memsize)
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // The selected lane is brought down to bit 0 before extension.
  always_comb begin
    shifted = bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = REQ;
      REQ: begin
        if (bus_ack)          state_next = DONE;
        else if (timeout_hit) state_next = ERR;
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus_req  = (state == REQ);
    bus_err  = (state == ERR);
    stall    = start | (state == REQ);
    misalign = (state == IDLE) & valid_i & misaligned;
  end

  // Bus fields are captured on IDLE->REQ so they stay stable for the whole request.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      rdata     <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      off_q     <= '0;
      size_q    <= '0;
      signed_q  <= 1'b0;
    end else if (start) begin
      cnt       <= '0;
      bus_we    <= memwrite;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_be    <= be_calc;
      bus_wdata <= wdata_calc;
      off_q     <= addr[1:0];
      size_q    <= memsize;
      signed_q  <= memsigned;
    end else if (state == REQ) begin
      if (bus_ack) begin
        if (!bus_we) rdata <= load_val;
      end else begin
        cnt <= cnt + 1'b1;
        if (timeout_hit) rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, memwrite, memsigned;
  logic [1:0]  memsize;
  logic [31:0] addr, wdata, rdata, bus_addr, bus_wdata, bus_rdata;
  logic        stall, misalign, bus_err, bus_req, bus_we, bus_ack;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic        cap_we;
  int          stall_cyc, req_cyc;
  logic        err_seen, mis_seen;

  mem_access_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .memwrite(memwrite),
    .memsize(memsize), .memsigned(memsigned), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misalign(misalign), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one instruction and follows it until stall drops (DONE/ERR cycle or misaligned IDLE).
  task automatic run_access(input logic we, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rd, input int ack_at);
    valid_i = 1'b1; memwrite = we; memsize = sz; memsigned = sg;
    addr = a; wdata = wd; bus_rdata = rd; bus_ack = 1'b0;
    stall_cyc = 0; req_cyc = 0; err_seen = 1'b0; mis_seen = 1'b0;
    cap_addr = '0; cap_wdata = '0; cap_be = '0; cap_we = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (misalign) mis_seen = 1'b1;
      if (bus_err) err_seen = 1'b1;
      if (stall) stall_cyc++;
      if (bus_req) begin
        req_cyc++;
        cap_addr = bus_addr; cap_wdata = bus_wdata; cap_be = bus_be; cap_we = bus_we;
        bus_ack = (req_cyc == ack_at);
      end else begin
        bus_ack = 1'b0;
      end
      if (!stall) break;
      if (i == 39) chk("access_bound", 32'(i), 32'hFFFF_FFFF);
      @(posedge clk);
    end
  endtask

  task automatic end_access(input string tag);
    @(posedge clk);
    valid_i = 1'b0; bus_ack = 1'b0;
    #1;
    chk({tag, "_req_after"}, 32'(bus_req), 32'd0);
    chk({tag, "_err_after"}, 32'(bus_err), 32'd0);
  endtask

  initial begin
    reset = 1'b1; valid_i = 1'b0; memwrite = 1'b0; memsize = 2'b00; memsigned = 1'b0;
    addr = '0; wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);

    // word store, ack on first REQ cycle
    run_access(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_be", 32'(cap_be), 32'hF);
    chk("sw_we", 32'(cap_we), 32'd1);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_stall", 32'(stall_cyc), 32'd2);
    chk("sw_mis", 32'(mis_seen), 32'd0);
    chk("sw_rdata", rdata, 32'h0);
    end_access("sw");

    // lb signed / unsigned at lane 3
    run_access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 32'h80FF1234, 1);
    chk("lbs_be", 32'(cap_be), 32'h8);
    chk("lbs_addr", cap_addr, 32'h200);
    chk("lbs_we", 32'(cap_we), 32'd0);
    chk("lbs_rdata", rdata, 32'hFFFFFF80);
    end_access("lbs");
    run_access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 32'h80FF1234, 2);
    chk("lbu_rdata", rdata, 32'h00000080);
    chk("lbu_stall", 32'(stall_cyc), 32'd3);
    end_access("lbu");

    // lh signed, upper half
    run_access(1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 32'hBEEF0000, 1);
    chk("lh_be", 32'(cap_be), 32'hC);
    chk("lh_rdata", rdata, 32'hFFFFBEEF);
    end_access("lh");

    // sb at lane 1
    run_access(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000A5, 32'h0, 1);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("sb_addr", cap_addr, 32'h10);
    chk("sb_rdata_kept", rdata, 32'hFFFFBEEF);
    end_access("sb");

    // misaligned accesses never reach the bus
    run_access(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'h0, 1);
    chk("mis_w_flag", 32'(mis_seen), 32'd1);
    chk("mis_w_req", 32'(req_cyc), 32'd0);
    chk("mis_w_stall", 32'(stall_cyc), 32'd0);
    end_access("mis_w");
    run_access(1'b1, 2'b01, 1'b0, 32'h101, 32'h0, 32'h0, 1);
    chk("mis_h_flag", 32'(mis_seen), 32'd1);
    chk("mis_h_req", 32'(req_cyc), 32'd0);
    end_access("mis_h");
    run_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1);
    chk("mis_s_flag", 32'(mis_seen), 32'd1);
    chk("mis_s_req", 32'(req_cyc), 32'd0);
    chk("mis_s_stall", 32'(stall_cyc), 32'd0);
    end_access("mis_s");

    // timeout: 16 REQ cycles, then one-cycle bus_err with rdata cleared
    run_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h11111111, 0);
    chk("to_req_cycles", 32'(req_cyc), 32'd16);
    chk("to_err", 32'(err_seen), 32'd1);
    chk("to_rdata", rdata, 32'h0);
    chk("to_stall", 32'(stall), 32'd0);
    end_access("to");

    // ack on the 16th REQ cycle wins over the timeout
    run_access(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'h12345678, 16);
    chk("late_req_cycles", 32'(req_cyc), 32'd16);
    chk("late_err", 32'(err_seen), 32'd0);
    chk("late_rdata", rdata, 32'h12345678);
    end_access("late");

    // reset on the 3rd REQ cycle, then a stray ack
    valid_i = 1'b1; memwrite = 1'b0; memsize = 2'b10; addr = 32'h500; bus_rdata = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mid_req_before", 32'(bus_req), 32'd1);
    reset = 1'b1; valid_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_mid_req_after", 32'(bus_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_err", 32'(bus_err), 32'd0);
    bus_ack = 1'b1;
    @(posedge clk);
    #1 bus_ack = 1'b0;
    chk("stray_ack_rdata", rdata, 32'h0);
    chk("stray_ack_req", 32'(bus_req), 32'd0);
    chk("stray_ack_err", 32'(bus_err), 32'd0);
    chk("stray_ack_stall", 32'(stall), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage sitting directly downstream of the ALU.
- Takes the ALU result as the effective address, plus register write data and decoded memory-op controls.
- Runs a request/acknowledge transaction on the data-memory bus, with byte-lane steering, sign/zero extension, misalignment detection and an access timeout.
- Holds the single-cycle datapath via `stall` until the access completes.

Parameters:
- TIMEOUT, 16, maximum cycles `bus_req` may stay high without `bus_ack` before the access is aborted (must be ≥ 2).
- CNT_W, 5, width of the timeout counter (must satisfy 2^CNT_W > TIMEOUT).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- valid_i  input  1  current instruction is a load or store.
- memwrite  input  1  1 = store, 0 = load.
- memsize  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- memsigned  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  input  32  effective address (ALU result).
- wdata  input  32  store data, right-aligned.
- rdata  output  32  load result, extended to 32 bits.
- stall  output  1  hold PC and register-file write.
- misalign  output  1  alignment fault for the current instruction.
- bus_err  output  1  one-cycle pulse when an access times out.
- bus_req  output  1  transaction request.
- bus_we  output  1  transaction is a write.
- bus_addr  output  32  word address, i.e. {addr[31:2], 2'b00}.
- bus_be  output  4  byte enables; bit k enables lane k (bits 8k+7:8k).
- bus_wdata  output  32  lane-replicated write data.
- bus_rdata  input  32  read data; valid when `bus_ack` = 1.
- bus_ack  input  1  transaction complete.

Behaviour:
- Little-endian byte lanes; byte offset = addr[1:0].
- Misaligned when any of:
  - memsize = 01 and addr[0] = 1;
  - memsize = 10 and addr[1:0] ≠ 00;
  - memsize = 11.
- FSM states and transitions:
  - IDLE: if valid_i and aligned → REQ. If valid_i and misaligned → `misalign` = 1 (combinational), no bus activity, stall = 0, stay in IDLE.
  - REQ: bus_req = 1, with addr/we/be/wdata registered on IDLE→REQ and held stable.
    - bus_ack → DONE. On a load, capture the extracted `rdata` in the same edge.
    - Counter reaches TIMEOUT without ack → ERR.
  - DONE: one cycle, stall = 0, `rdata` valid; → IDLE. `valid_i` during DONE is the completing instruction, never a new request.
  - ERR: one cycle, bus_err = 1, stall = 0, rdata = 0; → IDLE.
- Stall is combinational: stall = (IDLE and valid_i and aligned) or REQ. Minimum access latency is 2 stall cycles when ack arrives in the first REQ cycle.
- Timeout counter:
  - cleared on entry to REQ;
  - increments each REQ cycle without ack;
  - ack in the same cycle the counter hits TIMEOUT wins (→ DONE).
- Byte enables:
  - byte: one-hot at addr[1:0];
  - half: 0011 (addr[1] = 0) or 1100 (addr[1] = 1);
  - word: 1111.
  - bus_be = 0 for loads as well as stores? No — for loads bus_be carries the same pattern; memory may ignore it.
- Write data lanes:
  - byte: {4{wdata[7:0]}};
  - half: {2{wdata[15:0]}};
  - word: wdata.
- Load extraction: the selected lane is shifted to bit 0, then extended to 32 bits by sign (memsigned = 1) or zero (memsigned = 0). Word loads ignore memsigned.
- rdata holds its last value until the next completed load or ERR.
- Reset values:
  - state IDLE, counter 0, rdata 0;
  - bus_req, bus_we, bus_be, bus_addr, bus_wdata all 0;
  - bus_err 0. stall and misalign follow their combinational equations.
- Reset mid-transaction: bus_req is low the cycle after reset is sampled, with no DONE or ERR pulse. A late bus_ack received in IDLE is ignored.
- bus_ack outside REQ is always ignored.

Test Plan:
- Word store: addr = 0x100, wdata = 0xDEADBEEF, ack on 1st REQ cycle.
  → bus_addr = 0x100, be = 1111, we = 1, stall high for 2 cycles, no misalign.
- lb signed: addr = 0x203, bus_rdata = 0x80FF_1234, memsigned = 1 → be = 1000, rdata = 0xFFFFFF80.
- Same access with memsigned = 0 → rdata = 0x00000080.
- lh at addr = 0x202, bus_rdata = 0xBEEF0000, signed → be = 1100, rdata = 0xFFFFBEEF.
- sb at addr = 0x11, wdata = 0x0000_00A5 → be = 0010, bus_wdata = 0xA5A5A5A5.
- Misalign: word at 0x102, half at 0x101, memsize = 11.
  → misalign = 1 for each, bus_req never asserted, stall = 0.
- Timeout (TIMEOUT = 16): no ack → bus_err pulses 1 cycle after 16 REQ cycles, rdata = 0, stall drops.
- Ack on the 16th REQ cycle → DONE, no bus_err.
- Reset asserted on the 3rd REQ cycle → bus_req = 0 next cycle, state IDLE. An ack one cycle later changes nothing: rdata unchanged.
